// File: rtl/hex_master_pkg.sv
// Shared types and constants for the hex score writer master.
package hex_master_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 16;
    localparam int SAT_MAX    = 9999;

    // Double-dabble correction: add 3 to every digit that is 5 or more,
    // so the following left shift carries correctly into the next digit.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative binary-to-packed-BCD converter, one input bit per clock.
// The start cycle already shifts in the MSB, so done pulses VAL_W cycles
// after start and bcd holds the result from that cycle on.
module bin2bcd_iter
    import hex_master_pkg::*;
#(
    parameter int VAL_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [VAL_W-1:0] sh_q, sh_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic [BCD_W-1:0] adj;

    // One shift-add-3 step per cycle; start loads and performs the first step.
    always_comb begin
        sh_d     = sh_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = 1'b0;
        adj      = bcd_adjust(bcd_q);
        if (start) begin
            bcd_d    = BCD_W'(bin[VAL_W-1]);
            sh_d     = bin << 1;
            cnt_d    = CNT_W'(1);
            active_d = (VAL_W > 1);
            done_d   = (VAL_W == 1);
        end else if (active_q) begin
            bcd_d = (adj << 1) | BCD_W'(sh_q[VAL_W-1]);
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(VAL_W - 1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    // Conversion state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q     <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/hex_score_writer_master.sv
// Avalon-MM master: takes a binary score, converts it to 4-digit BCD,
// writes it to the hex display PIO and optionally reads it back to verify.
module hex_score_writer_master
    import hex_master_pkg::*;
#(
    parameter int              VAL_W    = 14,
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PIO_BASE = '0,
    parameter bit              VERIFY   = 1'b1,
    parameter int              TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              score_valid,
    output logic              score_ready,
    input  logic [VAL_W-1:0]  score_value,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic              avm_read,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              verify_err,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              write_q, write_d;
    logic              read_q, read_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              verr_q, verr_d;
    logic              terr_q, terr_d;
    logic [CNT_W-1:0]  wait_q, wait_d;

    logic              accept;
    logic [VAL_W-1:0]  sat_value;
    logic              conv_done;
    logic [BCD_W-1:0]  conv_bcd;
    logic              unused_readdata;

    assign accept          = score_valid && ready_q;
    assign sat_value       = (32'(score_value) > 32'(SAT_MAX)) ? VAL_W'(SAT_MAX) : score_value;
    assign unused_readdata = &{1'b0, avm_readdata[31:16]};

    bin2bcd_iter #(.VAL_W(VAL_W)) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .bin   (sat_value),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Next-state and registered-output logic for the transfer sequencer.
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        write_d = write_q;
        read_d  = read_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        verr_d  = verr_q;
        terr_d  = terr_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CONV;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    verr_d  = 1'b0;
                    terr_d  = 1'b0;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_d = WRITE;
                    write_d = 1'b1;
                    addr_d  = PIO_BASE;
                    wdata_d = {16'h0000, conv_bcd};
                    wait_d  = '0;
                end
            end
            WRITE, READ: begin
                if (!avm_waitrequest) begin
                    write_d = 1'b0;
                    read_d  = 1'b0;
                    wait_d  = '0;
                    if (state_q == WRITE && VERIFY) begin
                        state_d = READ;
                        read_d  = 1'b1;
                    end else begin
                        if (state_q == READ && avm_readdata[15:0] != wdata_q[15:0]) begin
                            verr_d = 1'b1;
                        end
                        state_d = IDLE;
                        addr_d  = '0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
                    // Slave stalled too long: drop the request and give up on this score.
                    write_d = 1'b0;
                    read_d  = 1'b0;
                    terr_d  = 1'b1;
                    state_d = IDLE;
                    addr_d  = '0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            verr_q  <= 1'b0;
            terr_q  <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            write_q <= write_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            verr_q  <= verr_d;
            terr_q  <= terr_d;
            wait_q  <= wait_d;
        end
    end

    assign score_ready   = ready_q;
    assign busy          = busy_q;
    assign avm_write     = write_q;
    assign avm_read      = read_q;
    assign avm_address   = addr_q;
    assign avm_writedata = wdata_q;
    assign verify_err    = verr_q;
    assign timeout_err   = terr_q;

endmodule
